// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared types and default timing constants for the DDR4 refresh scheduler
//
// Contents:
//   refresh_state_e : refresh FSM state encoding (IDLE, COUNT, PREA, REF, RFC)
//   DEF_*           : default DDR4 refresh timing in controller clock cycles
//   DEBT_W          : width of the postponed-refresh debt counter

package ddr_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        PREA  = 3'd2,
        REF   = 3'd3,
        RFC   = 3'd4
    } refresh_state_e;

    localparam int unsigned DEF_T_REFI       = 6240;
    localparam int unsigned DEF_T_RFC        = 280;
    localparam int unsigned DEF_ALMOST_LEAD  = 64;
    localparam int unsigned DEF_MAX_POSTPONE = 8;
    localparam int unsigned DEF_CNT_W        = 16;

    // Debt counts 0..MAX_POSTPONE; DDR4 allows at most 8 postponed refreshes.
    localparam int unsigned DEBT_W = 4;

endpackage

// File: rtl/ddr_refresh_timer.sv
// rtl/ddr_refresh_timer.sv - tREFI interval down-counter with reload, expire pulse and almost flag
//
// Ports:
//   clk      in   controller clock
//   reset_n  in   synchronous active-low reset
//   load     in   restart the interval (timer = T_REFI-1)
//   run      in   count down this cycle
//   expire   out  high for the cycle in which the timer sits at 0 while running
//   almost   out  registered: timer was within ALMOST_LEAD of expiry last cycle

module ddr_refresh_timer
    import ddr_pkg::*;
#(
    parameter int unsigned T_REFI      = DEF_T_REFI,
    parameter int unsigned ALMOST_LEAD = DEF_ALMOST_LEAD,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic run,
    output logic expire,
    output logic almost
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(T_REFI - 1);
    localparam logic [CNT_W-1:0] LEAD   = CNT_W'(ALMOST_LEAD);

    logic [CNT_W-1:0] timer;

    // The zero cycle is the expiry cycle itself; the reload happens on the
    // same edge, so consecutive expiries are exactly T_REFI cycles apart.
    assign expire = run && (timer == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer  <= RELOAD;
            almost <= 1'b0;
        end else if (load) begin
            timer  <= RELOAD;
            almost <= 1'b0;
        end else if (run) begin
            timer  <= expire ? RELOAD : (timer - CNT_W'(1));
            almost <= (timer <= LEAD);
        end else begin
            almost <= 1'b0;
        end
    end

endmodule

// File: rtl/ddr_refresh_ctrl.sv
// rtl/ddr_refresh_ctrl.sv - DDR4 refresh scheduler: interval tracking, refresh debt, PREA/REF/tRFC sequencing
//
// Ports:
//   clk             in   controller clock
//   reset_n         in   synchronous active-low reset
//   ini_done        in   initialization complete (latched by leaving IDLE)
//   rw_idle         in   no read/write burst in flight
//   act_idle        in   all banks precharged
//   prea_req        out  level, request precharge-all
//   refresh_rdy     out  one-cycle REF command strobe
//   refresh_done    out  one-cycle pulse on the last tRFC cycle
//   refresh_almost  out  interval near expiry or refresh debt outstanding
//   busy            out  block new ACT (refresh sequence active or debt saturated)
//   debt            out  postponed-refresh count
//   postpone_err    out  sticky, interval expired with debt already saturated

module ddr_refresh_ctrl
    import ddr_pkg::*;
#(
    parameter int unsigned T_REFI       = DEF_T_REFI,
    parameter int unsigned T_RFC        = DEF_T_RFC,
    parameter int unsigned ALMOST_LEAD  = DEF_ALMOST_LEAD,
    parameter int unsigned MAX_POSTPONE = DEF_MAX_POSTPONE,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ini_done,
    input  logic              rw_idle,
    input  logic              act_idle,
    output logic              prea_req,
    output logic              refresh_rdy,
    output logic              refresh_done,
    output logic              refresh_almost,
    output logic              busy,
    output logic [DEBT_W-1:0] debt,
    output logic              postpone_err
);

    localparam logic [CNT_W-1:0]  RFC_LOAD = CNT_W'(T_RFC - 1);
    localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_POSTPONE);

    refresh_state_e    state;
    refresh_state_e    state_nxt;
    logic [CNT_W-1:0]  rfc_cnt;
    logic [DEBT_W-1:0] debt_q;
    logic              err_q;

    logic timer_load;
    logic timer_run;
    logic expire;
    logic timer_almost;
    logic want_ref;
    logic debt_dec;

    // ini_done only matters in IDLE; once COUNT is entered it is never
    // consulted again, which is what latches it.
    assign timer_load = (state == IDLE) && ini_done;
    assign timer_run  = (state != IDLE);

    ddr_refresh_timer #(
        .T_REFI      (T_REFI),
        .ALMOST_LEAD (ALMOST_LEAD),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (timer_load),
        .run     (timer_run),
        .expire  (expire),
        .almost  (timer_almost)
    );

    // Refresh is only launched between bursts, even when debt is saturated;
    // saturation merely raises busy so the burst stream drains.
    assign want_ref = (debt_q != '0) && rw_idle;

    // Debt is consumed during the REF cycle itself.
    assign debt_dec = (state == REF);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ini_done) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (want_ref) begin
                    state_nxt = act_idle ? REF : PREA;
                end
            end
            PREA: begin
                if (act_idle) begin
                    state_nxt = REF;
                end
            end
            REF: begin
                state_nxt = RFC;
            end
            RFC: begin
                // The final tRFC cycle makes the same decision COUNT would,
                // so back-to-back refreshes are T_RFC+1 cycles apart.
                if (rfc_cnt == '0) begin
                    if (want_ref) begin
                        state_nxt = act_idle ? REF : PREA;
                    end else begin
                        state_nxt = COUNT;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rfc_cnt <= '0;
        end else if (state == REF) begin
            rfc_cnt <= RFC_LOAD;
        end else if ((state == RFC) && (rfc_cnt != '0)) begin
            rfc_cnt <= rfc_cnt - CNT_W'(1);
        end
    end

    // An expiry coinciding with the REF cycle cancels out. REF is only
    // entered with debt > 0, so the decrement cannot underflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            debt_q <= '0;
            err_q  <= 1'b0;
        end else if (expire && !debt_dec) begin
            if (debt_q == DEBT_MAX) begin
                err_q <= 1'b1;
            end else begin
                debt_q <= debt_q + DEBT_W'(1);
            end
        end else if (debt_dec && !expire) begin
            debt_q <= debt_q - DEBT_W'(1);
        end
    end

    assign prea_req       = (state == PREA);
    assign refresh_rdy    = (state == REF);
    assign refresh_done   = (state == RFC) && (rfc_cnt == '0);
    assign refresh_almost = timer_almost || (debt_q != '0);
    assign busy           = (state == PREA) || (state == REF) || (state == RFC) ||
                            (debt_q == DEBT_MAX);
    assign debt           = debt_q;
    assign postpone_err   = err_q;

endmodule

// File: tb/tb_ddr_refresh_ctrl.sv
// tb/tb_ddr_refresh_ctrl.sv - directed table-driven bench for ddr_refresh_ctrl

module tb_ddr_refresh_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ini_done;
    logic       rw_idle;
    logic       act_idle;
    logic       prea_req;
    logic       refresh_rdy;
    logic       refresh_done;
    logic       refresh_almost;
    logic       busy;
    logic [3:0] debt;
    logic       postpone_err;

    ddr_refresh_ctrl #(
        .T_REFI       (100),
        .T_RFC        (20),
        .ALMOST_LEAD  (10),
        .MAX_POSTPONE (8),
        .CNT_W        (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ini_done       (ini_done),
        .rw_idle        (rw_idle),
        .act_idle       (act_idle),
        .prea_req       (prea_req),
        .refresh_rdy    (refresh_rdy),
        .refresh_done   (refresh_done),
        .refresh_almost (refresh_almost),
        .busy           (busy),
        .debt           (debt),
        .postpone_err   (postpone_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic rw_next;
        logic act_next;
        logic prea;
        logic rdy;
        logic done;
        logic alm;
        logic bsy;
        int   dbt;
        logic err;
    } vec_t;

    vec_t vecs[$];
    int   cyc;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rdy_seen[$];
    int   rdy_exp[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Advance one clock; cyc names the edge just taken, outputs are read 1ns later.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (refresh_rdy) rdy_seen.push_back(cyc);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    function automatic vec_t v(input int c, input logic rw, input logic act,
                               input logic prea, input logic rdy, input logic done,
                               input logic alm, input logic bsy, input int dbt,
                               input logic err);
        vec_t r;
        r.cyc = c; r.rw_next = rw; r.act_next = act;
        r.prea = prea; r.rdy = rdy; r.done = done; r.alm = alm;
        r.bsy = bsy; r.dbt = dbt; r.err = err;
        return r;
    endfunction

    task automatic chk_all(input string pfx, input logic prea, input logic rdy,
                           input logic done, input logic alm, input logic bsy,
                           input int dbt, input logic err);
        chk({pfx, ".prea_req"}, int'(prea_req), int'(prea));
        chk({pfx, ".refresh_rdy"}, int'(refresh_rdy), int'(rdy));
        chk({pfx, ".refresh_done"}, int'(refresh_done), int'(done));
        chk({pfx, ".refresh_almost"}, int'(refresh_almost), int'(alm));
        chk({pfx, ".busy"}, int'(busy), int'(bsy));
        chk({pfx, ".debt"}, int'(debt), dbt);
        chk({pfx, ".postpone_err"}, int'(postpone_err), int'(err));
    endtask

    initial begin
        int bad;
        int base;

        reset_n  = 1'b0;
        ini_done = 1'b0;
        rw_idle  = 1'b1;
        act_idle = 1'b1;
        cyc      = -20;
        repeat (3) tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        repeat (3) tick();
        chk_all("pre_init", 0, 0, 0, 0, 0, 0, 0);

        // Edge 0 samples ini_done; dropping it afterwards must not matter.
        ini_done = 1'b1;
        cyc = -1;
        tick();
        ini_done = 1'b0;

        //            cyc   rw act  prea rdy done alm busy debt err
        // idle refresh
        vecs.push_back(v(0,    1, 1,   0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(89,   1, 1,   0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(90,   1, 1,   0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v(99,   1, 1,   0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v(100,  1, 1,   0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(v(101,  1, 1,   0, 1, 0, 1, 1, 1, 0));
        vecs.push_back(v(102,  1, 1,   0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(120,  1, 1,   0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(121,  1, 1,   0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(v(122,  1, 1,   0, 0, 0, 0, 0, 0, 0));
        // precharge-all path: banks open at the 200 expiry, closed at 210
        vecs.push_back(v(150,  1, 0,   0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(200,  1, 0,   0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(v(201,  1, 0,   1, 0, 0, 1, 1, 1, 0));
        vecs.push_back(v(210,  1, 1,   1, 0, 0, 1, 1, 1, 0));
        vecs.push_back(v(211,  1, 1,   0, 1, 0, 1, 1, 1, 0));
        vecs.push_back(v(212,  1, 1,   0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(231,  1, 1,   0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(v(232,  0, 1,   0, 0, 0, 0, 0, 0, 0));
        // postponement to saturation, then drain
        vecs.push_back(v(300,  0, 1,   0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(v(301,  0, 1,   0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(v(999,  0, 1,   0, 0, 0, 1, 0, 7, 0));
        vecs.push_back(v(1000, 1, 1,   0, 0, 0, 1, 1, 8, 0));
        vecs.push_back(v(1001, 1, 1,   0, 1, 0, 1, 1, 8, 0));
        vecs.push_back(v(1190, 0, 1,   0, 0, 0, 1, 0, 0, 0));
        // coincidence: REF cycle 1299 meets the 1300 expiry
        vecs.push_back(v(1200, 0, 1,   0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(v(1298, 1, 1,   0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(v(1299, 1, 1,   0, 1, 0, 1, 1, 1, 0));
        vecs.push_back(v(1300, 1, 1,   0, 0, 0, 1, 1, 1, 0));
        vecs.push_back(v(1319, 1, 1,   0, 0, 1, 1, 1, 1, 0));
        vecs.push_back(v(1320, 0, 1,   0, 1, 0, 1, 1, 1, 0));
        vecs.push_back(v(1321, 0, 1,   0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(1340, 0, 1,   0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(v(1341, 0, 1,   0, 0, 0, 0, 0, 0, 0));
        // overflow: nine intervals without a refresh
        vecs.push_back(v(2099, 0, 1,   0, 0, 0, 1, 0, 7, 0));
        vecs.push_back(v(2100, 0, 1,   0, 0, 0, 1, 1, 8, 0));
        vecs.push_back(v(2199, 0, 1,   0, 0, 0, 1, 1, 8, 0));
        vecs.push_back(v(2200, 1, 1,   0, 0, 0, 1, 1, 8, 1));
        vecs.push_back(v(2201, 1, 1,   0, 1, 0, 1, 1, 8, 1));
        vecs.push_back(v(2202, 1, 1,   0, 0, 0, 1, 1, 7, 1));

        foreach (vecs[i]) begin
            run_to(vecs[i].cyc);
            chk_all($sformatf("row%0d", i), vecs[i].prea, vecs[i].rdy, vecs[i].done,
                    vecs[i].alm, vecs[i].bsy, vecs[i].dbt, vecs[i].err);
            rw_idle  = vecs[i].rw_next;
            act_idle = vecs[i].act_next;
        end

        // Reset in the middle of tRFC: everything clears at once, no late done.
        run_to(2210);
        reset_n  = 1'b0;
        ini_done = 1'b0;
        tick();
        chk_all("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        bad = 0;
        while (cyc < 2225) begin
            tick();
            if (refresh_done || refresh_rdy) bad++;
        end
        chk("rst_no_strobe", bad, 0);

        // Without ini_done the block must stay quiet.
        reset_n = 1'b1;
        bad = 0;
        repeat (150) begin
            tick();
            if (refresh_almost || busy || prea_req || refresh_rdy || refresh_done ||
                debt != 4'd0 || postpone_err) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Re-initialise: first expiry T_REFI cycles after the sampling edge.
        ini_done = 1'b1;
        base = cyc + 1;
        tick();
        ini_done = 1'b0;
        run_to(base + 99);
        chk("reinit_debt_pre", int'(debt), 0);
        run_to(base + 100);
        chk("reinit_debt", int'(debt), 1);
        run_to(base + 125);
        chk("reinit_drain", int'(debt), 0);

        rdy_exp = '{101, 211, 1001, 1022, 1043, 1064, 1085, 1106, 1127, 1148,
                    1169, 1299, 1320, 2201};
        rdy_exp.push_back(base + 101);
        chk("rdy_count", rdy_seen.size(), rdy_exp.size());
        foreach (rdy_exp[i]) begin
            if (i < rdy_seen.size()) chk($sformatf("rdy_cycle%0d", i), rdy_seen[i], rdy_exp[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
